// File: rtl/pipe_front_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_front_ctrl_pkg
// Shared CPU definitions for the pipeline front end and the hazard unit:
// the reset fetch address, the nop encoding, the instruction field layout
// (op, rs, rt, rd, shamt, func) and the pipeline register payload types.
// ----------------------------------------------------------------------------
package pipe_front_ctrl_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    // Instruction field layout, MSB first: op[31:26] rs[25:21] rt[20:16]
    // rd[15:11] shamt[10:6] func[5:0].
    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] func;
    } instr_t;

    // F/D pipeline register payload.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fd_t;

    // D/E pipeline register payload; valid rides along so a bubble clears it.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
    } de_t;

    function automatic logic is_nop(input instr_t instr);
        return instr == instr_t'(NOP);
    endfunction

    // Branch targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// ----------------------------------------------------------------------------
// pipe_reg
// Generic pipeline register with synchronous active-low reset, clear and hold.
// Priority: reset, clear (load zero), hold (keep), else load d.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   hold   - keep current contents
//   clear  - load all zeros (bubble)
//   d      - next contents
//   q      - registered contents
// ----------------------------------------------------------------------------
module pipe_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_front_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_front_ctrl
// Fetch/decode front end of a five-stage pipeline: PC sequencing with
// branch redirect (one delay slot), the F/D and D/E pipeline registers,
// bubble insertion on stall, and a saturating stall-cycle counter.
// Stall comes from an external hazard unit and is only consumed here.
// Ports:
//   clk, reset              - clock; synchronous active-low reset
//   Stall                   - freeze PC and F/D, insert a bubble into E
//   BranchTaken/Target      - redirect fetch from D (ignored while stalled)
//   InstrF                  - instruction memory word at PCF
//   RD1D, RD2D, ExtD        - register reads and immediate in D
//   PCF                     - fetch address
//   InstrD, PCD             - F/D register
//   InstrE, PCE, RD1E, RD2E, ExtE, ValidE - D/E register
//   StallCnt                - saturating count of stalled cycles
// ----------------------------------------------------------------------------
module pipe_front_ctrl
    import pipe_front_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    input  logic [31:0]      InstrF,
    input  logic [31:0]      RD1D,
    input  logic [31:0]      RD2D,
    input  logic [31:0]      ExtD,
    output logic [31:0]      PCF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCD,
    output logic [31:0]      InstrE,
    output logic [31:0]      PCE,
    output logic [31:0]      RD1E,
    output logic [31:0]      RD2E,
    output logic [31:0]      ExtE,
    output logic             ValidE,
    output logic [CNT_W-1:0] StallCnt
);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q;
    fd_t              fd_d, fd_q;
    de_t              de_d, de_q;

    // A stalled branch is dropped; it re-evaluates in D next cycle.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (Stall) begin
            pc_d = pc_q;
        end else if (BranchTaken) begin
            pc_d = word_align(BranchTarget);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (Stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // F/D is never flushed on a branch: the slot instruction proceeds.
    always_comb begin
        fd_d       = '0;
        fd_d.instr = InstrF;
        fd_d.pc    = pc_q;
    end

    pipe_reg #(
        .W($bits(fd_t))
    ) u_fd_reg (
        .clk   (clk),
        .rst_n (reset),
        .hold  (Stall),
        .clear (1'b0),
        .d     (fd_d),
        .q     (fd_q)
    );

    always_comb begin
        de_d       = '0;
        de_d.valid = !is_nop(instr_t'(fd_q.instr));
        de_d.instr = fd_q.instr;
        de_d.pc    = fd_q.pc;
        de_d.rd1   = RD1D;
        de_d.rd2   = RD2D;
        de_d.ext   = ExtD;
    end

    // Clearing D/E on stall both zeroes the payload and drops ValidE.
    pipe_reg #(
        .W($bits(de_t))
    ) u_de_reg (
        .clk   (clk),
        .rst_n (reset),
        .hold  (1'b0),
        .clear (Stall),
        .d     (de_d),
        .q     (de_q)
    );

    assign PCF      = pc_q;
    assign InstrD   = fd_q.instr;
    assign PCD      = fd_q.pc;
    assign InstrE   = de_q.instr;
    assign PCE      = de_q.pc;
    assign RD1E     = de_q.rd1;
    assign RD2E     = de_q.rd2;
    assign ExtE     = de_q.ext;
    assign ValidE   = de_q.valid;
    assign StallCnt = cnt_q;

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_front_ctrl
// Directed stimulus; expected register contents after each edge are queued
// and a negedge monitor pops and compares them. The counter width is
// shrunk so saturation is reachable in a handful of stall cycles.
// Instruction memory model: word at address a is {8'hA5, a[23:0]}, or zero
// while zero_fetch is set.
// ----------------------------------------------------------------------------
module tb_pipe_front_ctrl;

    localparam int unsigned CW = 4;

    typedef enum int {
        F_PCF, F_INSTRD, F_PCD, F_INSTRE, F_PCE, F_RD1E, F_RD2E, F_EXTE, F_VALIDE, F_CNT
    } field_e;

    typedef struct {
        int          cyc;
        field_e      f;
        logic [31:0] v;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, Stall, BranchTaken, zero_fetch;
    logic [31:0]   BranchTarget, InstrF, RD1D, RD2D, ExtD;
    logic [31:0]   PCF, InstrD, PCD, InstrE, PCE, RD1E, RD2E, ExtE;
    logic          ValidE;
    logic [CW-1:0] StallCnt;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign InstrF = zero_fetch ? 32'h0 : {8'hA5, PCF[23:0]};

    pipe_front_ctrl #(
        .PC_RESET (32'h0000_3000),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .InstrF       (InstrF),
        .RD1D         (RD1D),
        .RD2D         (RD2D),
        .ExtD         (ExtD),
        .PCF          (PCF),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .InstrE       (InstrE),
        .PCE          (PCE),
        .RD1E         (RD1E),
        .RD2E         (RD2E),
        .ExtE         (ExtE),
        .ValidE       (ValidE),
        .StallCnt     (StallCnt)
    );

    function automatic logic [31:0] actual(input field_e f);
        case (f)
            F_PCF:    return PCF;
            F_INSTRD: return InstrD;
            F_PCD:    return PCD;
            F_INSTRE: return InstrE;
            F_PCE:    return PCE;
            F_RD1E:   return RD1E;
            F_RD2E:   return RD2E;
            F_EXTE:   return ExtE;
            F_VALIDE: return {31'b0, ValidE};
            F_CNT:    return 32'(StallCnt);
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: every expectation is due at the negedge of the cycle it names.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            a = actual(e.f);
            n_cmp++;
            if (e.cyc != cyc || a !== e.v) begin
                n_err++;
                $display("FAIL %s (field %s, cyc %0d): got %h, want %h",
                         e.name, e.f.name(), e.cyc, a, e.v);
            end
        end
    end

    task automatic push(input field_e f, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.f    = f;
        e.v    = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] pcf, input logic [31:0] id, input logic [31:0] pd,
                       input logic [31:0] ie, input logic [31:0] pe, input logic ve,
                       input int cnt, input string nm);
        push(F_PCF, pcf, nm);
        push(F_INSTRD, id, nm);
        push(F_PCD, pd, nm);
        push(F_INSTRE, ie, nm);
        push(F_PCE, pe, nm);
        push(F_VALIDE, {31'b0, ve}, nm);
        push(F_CNT, cnt, nm);
    endtask

    task automatic chk_rd(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] ex,
                          input string nm);
        push(F_RD1E, r1, nm);
        push(F_RD2E, r2, nm);
        push(F_EXTE, ex, nm);
    endtask

    // Apply inputs for the coming edge, then advance to just past it.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt);
        Stall        = st;
        BranchTaken  = br;
        BranchTarget = tgt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        Stall        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = 32'h0;
        zero_fetch   = 1'b0;
        RD1D         = 32'h1111_1111;
        RD2D         = 32'h2222_2222;
        ExtD         = 32'h3333_3333;

        // Reset for two cycles, then run sequentially.
        step(0, 0, 0);
        chk(32'h3000, 0, 0, 0, 0, 0, 0, "reset1");
        step(0, 0, 0);
        chk(32'h3000, 0, 0, 0, 0, 0, 0, "reset2");
        n_cmp++;
        if (PCF !== 32'h3000) begin
            n_err++;
            $display("FAIL direct_reset_pcf: got %h, want %h", PCF, 32'h3000);
        end
        reset = 1'b1;
        step(0, 0, 0);
        chk(32'h3004, 32'hA500_3000, 32'h3000, 0, 0, 0, 0, "run1_nop_in_e");
        chk_rd(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, "run1_rd");
        n_cmp++;
        if (PCF !== 32'h3004) begin
            n_err++;
            $display("FAIL direct_run1_pcf: got %h, want %h", PCF, 32'h3004);
        end
        step(0, 0, 0);
        chk(32'h3008, 32'hA500_3004, 32'h3004, 32'hA500_3000, 32'h3000, 1, 0, "run2");

        // Taken branch at 3008; the delay-slot word reaches D.
        step(0, 1, 32'h3100);
        chk(32'h3100, 32'hA500_3008, 32'h3008, 32'hA500_3004, 32'h3004, 1, 0, "branch");
        n_cmp++;
        if (PCF !== 32'h3100 || InstrD !== 32'hA500_3008) begin
            n_err++;
            $display("FAIL direct_branch: got %h/%h, want %h/%h",
                     PCF, InstrD, 32'h3100, 32'hA500_3008);
        end
        step(0, 1, 32'h300F);
        chk(32'h300C, 32'hA500_3100, 32'h3100, 32'hA500_3008, 32'h3008, 1, 0, "branch_align");
        step(0, 0, 0);
        chk(32'h3010, 32'hA500_300C, 32'h300C, 32'hA500_3100, 32'h3100, 1, 0, "seq_3010");

        // Single stall at 3010.
        step(1, 0, 0);
        chk(32'h3010, 32'hA500_300C, 32'h300C, 0, 0, 0, 1, "stall1");
        chk_rd(0, 0, 0, "stall1_rd");
        n_cmp++;
        if (InstrE !== 32'h0 || ValidE !== 1'b0) begin
            n_err++;
            $display("FAIL direct_stall_bubble: got %h/%b, want %h/%b", InstrE, ValidE,
                     32'h0, 1'b0);
        end
        n_cmp++;
        if (StallCnt !== CW'(1)) begin
            n_err++;
            $display("FAIL direct_stall_cnt: got %h, want %h", StallCnt, CW'(1));
        end
        step(0, 0, 0);
        chk(32'h3014, 32'hA500_3010, 32'h3010, 32'hA500_300C, 32'h300C, 1, 1, "stall1_resume");

        // Stall with branch: branch ignored, then taken next cycle (3103 -> 3100).
        step(1, 1, 32'h3103);
        chk(32'h3014, 32'hA500_3010, 32'h3010, 0, 0, 0, 2, "stall_branch");
        RD1D = 32'hA1A1_A1A1;
        RD2D = 32'hB2B2_B2B2;
        ExtD = 32'hC3C3_C3C3;
        step(0, 1, 32'h3103);
        chk(32'h3100, 32'hA500_3014, 32'h3014, 32'hA500_3010, 32'h3010, 1, 2, "branch_after_stall");
        chk_rd(32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3, "branch_after_stall_rd");

        // Three consecutive stalls: frozen front, one bubble per cycle.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            chk(32'h3100, 32'hA500_3014, 32'h3014, 0, 0, 0, 3 + i, "stall3");
        end
        step(0, 0, 0);
        chk(32'h3104, 32'hA500_3100, 32'h3100, 32'hA500_3014, 32'h3014, 1, 5, "stall3_resume");

        // Saturation: 4-bit counter stops at 15.
        for (int k = 1; k <= 12; k++) begin
            step(1, 0, 0);
            chk(32'h3104, 32'hA500_3100, 32'h3100, 0, 0, 0, (5 + k > 15) ? 15 : 5 + k,
                "stall_sat");
        end
        step(0, 0, 0);
        chk(32'h3108, 32'hA500_3104, 32'h3104, 32'hA500_3100, 32'h3100, 1, 15, "sat_resume");

        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFFC);
        chk(32'hFFFF_FFFC, 32'hA500_3108, 32'h3108, 32'hA500_3104, 32'h3104, 1, 15, "to_top");
        step(0, 0, 0);
        chk(32'h0, 32'hA5FF_FFFC, 32'hFFFF_FFFC, 32'hA500_3108, 32'h3108, 1, 15, "wrap");
        n_cmp++;
        if (PCF !== 32'h0) begin
            n_err++;
            $display("FAIL direct_wrap: got %h, want %h", PCF, 32'h0);
        end
        step(0, 0, 0);
        chk(32'h4, 32'hA500_0000, 32'h0, 32'hA5FF_FFFC, 32'hFFFF_FFFC, 1, 15, "post_wrap");

        // A real nop (zero word) reaches E with ValidE=0 but its PC intact.
        zero_fetch = 1'b1;
        step(0, 0, 0);
        chk(32'h8, 32'h0, 32'h4, 32'hA500_0000, 32'h0, 1, 15, "nop_in_d");
        zero_fetch = 1'b0;
        step(0, 0, 0);
        chk(32'hC, 32'hA500_0008, 32'h8, 32'h0, 32'h4, 0, 15, "nop_in_e");
        step(0, 0, 0);
        chk(32'h10, 32'hA500_000C, 32'hC, 32'hA500_0008, 32'h8, 1, 15, "after_nop");

        // Reset in the middle of a three-cycle stall.
        step(1, 0, 0);
        chk(32'h10, 32'hA500_000C, 32'hC, 0, 0, 0, 15, "midstall1");
        reset = 1'b0;
        step(1, 1, 32'h4000);
        chk(32'h3000, 0, 0, 0, 0, 0, 0, "midstall_reset");
        chk_rd(0, 0, 0, "midstall_reset_rd");
        n_cmp++;
        if (StallCnt !== CW'(0) || PCF !== 32'h3000) begin
            n_err++;
            $display("FAIL direct_midstall_reset: got %h/%h, want %h/%h", StallCnt, PCF,
                     CW'(0), 32'h3000);
        end
        reset = 1'b1;
        step(1, 0, 0);
        chk(32'h3000, 0, 0, 0, 0, 0, 1, "midstall3");
        step(0, 0, 0);
        chk(32'h3004, 32'hA500_3000, 32'h3000, 0, 0, 0, 1, "after_reset_fetch");

        // Drain the scoreboard, bounded.
        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_err++;
            $display("FAIL %s: got no sample, want %h", e.name, e.v);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_front_ctrl.md
PIPE_FRONT_CTRL -- requirements
Module: pipe_front_ctrl

Interface
REQ-001 SHALL take parameter PC_RESET, default 32'h0000_3000, the first fetch address after reset.
REQ-002 SHALL take parameter CNT_W, default 32, the width of the stall counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset: synchronous, active-low.
REQ-005 SHALL have port Stall  input  1  hazard stall from the decode-stage hazard unit.
REQ-006 SHALL have port BranchTaken  input  1  the branch or jump in D redirects fetch.
REQ-007 SHALL have port BranchTarget  input  32  the redirect address computed in D.
REQ-008 SHALL have port InstrF  input  32  the instruction-memory word at PCF.
REQ-009 SHALL have ports RD1D, RD2D, ExtD  input  32 each  register-file reads and extended immediate in D.
REQ-010 SHALL have port PCF  output  32  the fetch address.
REQ-011 SHALL have ports InstrD, PCD  output  32 each  the F/D pipeline register.
REQ-012 SHALL have ports InstrE, PCE, RD1E, RD2E, ExtE  output  32 each  the D/E pipeline register.
REQ-013 SHALL have port ValidE  output  1  the E stage holds a real instruction, not a bubble.
REQ-014 SHALL have port StallCnt  output  CNT_W  the count of stalled cycles.

Function
REQ-015 SHALL update PCF each cycle with this priority: reset low -> PC_RESET; Stall -> hold; BranchTaken -> {BranchTarget[31:2],2'b00}; else PCF+4, wrapping modulo 2^32.
REQ-016 SHALL ignore BranchTaken while Stall=1, because the branch re-evaluates in D on the next cycle.
REQ-017 SHALL hold InstrD/PCD while Stall=1, else load InstrF/PCF; latency from F to D is 1 cycle.
REQ-018 SHALL NOT flush F/D on BranchTaken: the instruction fetched alongside a branch is the delay slot and proceeds to D.
REQ-019 SHALL, when Stall=1, load InstrE=0 (nop), PCE=0, RD1E=RD2E=ExtE=0 and ValidE=0; this is the bubble.
REQ-020 SHALL, when Stall=0, load InstrD, PCD, RD1D, RD2D, ExtD into the D/E register and set ValidE=1 iff InstrD != 0.
REQ-021 SHALL increment StallCnt on every cycle with Stall=1, saturating at all-ones with no wrap.
REQ-022 SHALL handle consecutive stall cycles, e.g. a load in M feeding a branch, as follows: PCF and F/D are frozen for every stall cycle, and one bubble is inserted into E per stall cycle.
REQ-023 SHALL give reset priority over Stall and BranchTaken in the same cycle.

Reset
REQ-024 SHALL, on reset low at a clock edge, set PCF=PC_RESET, zero F/D and D/E, set ValidE=0 and StallCnt=0.
REQ-025 SHALL, if reset is asserted mid-stall, abandon the stall; the first cycle after reset release fetches PC_RESET.
REQ-026 SHALL have no asynchronous state; no output changes between clock edges except through its input-to-register path.

Structure
REQ-027 SHALL use PC_RESET, the nop encoding 32'h0 and the instruction field ranges (op, rs, rt, rd, func) from the shared CPU definitions package that the hazard unit also uses.
REQ-028 SHALL factor the pipeline registers into one sub-module, pipe_reg, which has hold and clear controls and is instantiated once for F/D (hold=Stall, clear=0) and once for D/E (hold=0, clear=Stall).
REQ-029 SHALL contain no hazard detection; Stall is consumed only.

Verification
REQ-030 SHALL cover reset: hold reset low for 2 cycles, then release -> PCF=32'h3000, then 32'h3004, 32'h3008; StallCnt=0; ValidE=0 until the first non-zero instruction reaches E.
REQ-031 SHALL cover a single stall: Stall=1 for 1 cycle with PCF=32'h3010 -> PCF stays 32'h3010, InstrD is unchanged, InstrE=0 with ValidE=0, and StallCnt=1; the next cycle resumes at 32'h3014.
REQ-032 SHALL cover a taken branch: BranchTaken=1 with BranchTarget=32'h3100 and PCF=32'h3008 -> the next PCF is 32'h3100, and the instruction at 32'h3008 (the delay slot) appears in InstrD.
REQ-033 SHALL cover stall plus branch: Stall=1 and BranchTaken=1 together -> PCF holds; in the next cycle with Stall=0 and BranchTaken=1, PCF becomes the target.
REQ-034 SHALL cover boundaries: BranchTarget=32'h3103 gives PCF=32'h3100; PCF=32'hFFFF_FFFC with no stall or branch wraps to 32'h0; a bench with StallCnt forced near all-ones plus a stall stays saturated.
REQ-035 SHALL cover reset mid-stall: Stall=1 for 3 cycles and reset low in the 2nd -> all state is cleared, StallCnt=0, and after release PCF=32'h3000.
